// File: rtl/plca_rx_cmd_decode.sv
// PLCA receive command decoder: qualifies BEACON/COMMIT encodings on the
// MII receive path, tracks frames, and counts accepted BEACONs.
//
// Ports:
//   RX_CLK      in   sole clock, rising edge
//   reset       in   asynchronous active-high reset
//   plca_en     in   0 forces the idle state and outputs
//   RX_DV       in   MII receive data valid
//   RX_ER       in   MII receive error / extension
//   RXD[3:0]    in   MII receive nibble
//   rx_cmd[1:0] out  BEACON=00, COMMIT=01, NONE=10
//   CRS         out  carrier: qualified command or frame present
//   receiving   out  frame in progress
//   beacon_cnt  out  saturating count of BEACON entries
//   dec_state   out  current state (debug)

module plca_rx_cmd_decode #(
  parameter int CMD_QUAL = 2,
  parameter int CMD_HOLD = 1
) (
  input  logic       RX_CLK,
  input  logic       reset,
  input  logic       plca_en,
  input  logic       RX_DV,
  input  logic       RX_ER,
  input  logic [3:0] RXD,
  output logic [1:0] rx_cmd,
  output logic       CRS,
  output logic       receiving,
  output logic [7:0] beacon_cnt,
  output logic [2:0] dec_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QUAL    = 3'd1,
    S_BEACON  = 3'd2,
    S_COMMIT  = 3'd3,
    S_RECEIVE = 3'd4
  } state_t;

  localparam logic [1:0] C_BEACON = 2'b00;
  localparam logic [1:0] C_COMMIT = 2'b01;
  localparam logic [1:0] C_NONE   = 2'b10;

  localparam logic [3:0] L_QUAL = 4'(CMD_QUAL);
  localparam logic [3:0] L_HOLD = 4'(CMD_HOLD);

  state_t     r_state;
  logic [3:0] r_qual_cnt;
  logic [3:0] r_hold_cnt;
  logic [1:0] r_cand;
  logic [1:0] r_rx_cmd;
  logic       r_crs;
  logic       r_rcv;
  logic [7:0] r_bcnt;

  state_t     w_nstate;
  logic [3:0] w_nqual;
  logic [3:0] w_nhold;
  logic [1:0] w_ncand;
  logic       w_bcn;
  logic       w_cmt;
  logic       w_cmd;
  logic       w_data;
  logic [1:0] w_enc;
  logic [1:0] w_cur;
  logic [3:0] w_qual_inc;
  logic [3:0] w_hold_inc;

  assign w_data = RX_DV;
  assign w_bcn  = !RX_DV && RX_ER && (RXD == 4'h2);
  assign w_cmt  = !RX_DV && RX_ER && (RXD == 4'h3);
  assign w_cmd  = w_bcn || w_cmt;
  assign w_enc  = w_bcn ? C_BEACON : C_COMMIT;
  assign w_cur  = (r_state == S_BEACON) ? C_BEACON : C_COMMIT;

  // counters saturate so they can never wrap
  assign w_qual_inc = (r_qual_cnt == 4'hF) ? r_qual_cnt
                                           : r_qual_cnt + 4'd1;
  assign w_hold_inc = (r_hold_cnt == 4'hF) ? r_hold_cnt
                                           : r_hold_cnt + 4'd1;

  function automatic state_t cmd_state(input logic [1:0] c);
    return (c == C_BEACON) ? S_BEACON : S_COMMIT;
  endfunction

  always_comb begin
    w_nstate = r_state;
    w_nqual  = r_qual_cnt;
    w_nhold  = r_hold_cnt;
    w_ncand  = r_cand;
    unique case (r_state)
      S_IDLE: begin
        if (w_data) begin
          w_nstate = S_RECEIVE;
        end else if (w_cmd) begin
          w_ncand = w_enc;
          if (CMD_QUAL == 1) begin
            w_nstate = cmd_state(w_enc);
          end else begin
            w_nstate = S_QUAL;
            w_nqual  = 4'd1;
          end
        end
      end
      S_QUAL: begin
        if (w_data) begin
          w_nstate = S_RECEIVE;
        end else if (w_cmd && (w_enc == r_cand)) begin
          w_nqual = w_qual_inc;
          if (w_qual_inc >= L_QUAL) begin
            w_nstate = cmd_state(r_cand);
          end
        end else if (w_cmd) begin
          w_ncand = w_enc;
          w_nqual = 4'd1;
        end else begin
          w_nstate = S_IDLE;
        end
      end
      S_BEACON, S_COMMIT: begin
        if (w_data) begin
          w_nstate = S_RECEIVE;
        end else if (w_cmd && (w_enc == w_cur)) begin
          w_nhold = 4'd0;
        end else if (w_cmd) begin
          // direct switch between commands, no requalification
          w_nstate = cmd_state(w_enc);
          w_ncand  = w_enc;
        end else begin
          w_nhold = w_hold_inc;
          if (w_hold_inc >= L_HOLD) begin
            w_nstate = S_IDLE;
          end
        end
      end
      S_RECEIVE: begin
        if (!RX_DV) begin
          if (w_cmd) begin
            w_nstate = S_QUAL;
            w_ncand  = w_enc;
            w_nqual  = 4'd1;
          end else begin
            w_nstate = S_IDLE;
          end
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase

    if (!plca_en) begin
      w_nstate = S_IDLE;
      w_nqual  = 4'd0;
      w_nhold  = 4'd0;
      w_ncand  = C_NONE;
    end else if (w_nstate != r_state) begin
      // QUAL entry keeps its freshly loaded count of 1
      w_nhold = 4'd0;
      if (w_nstate != S_QUAL) begin
        w_nqual = 4'd0;
      end
    end
  end

  always_ff @(posedge RX_CLK or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_qual_cnt <= 4'd0;
      r_hold_cnt <= 4'd0;
      r_cand     <= C_NONE;
    end else begin
      r_state    <= w_nstate;
      r_qual_cnt <= w_nqual;
      r_hold_cnt <= w_nhold;
      r_cand     <= w_ncand;
    end
  end

  // outputs reflect the destination state of each transition
  always_ff @(posedge RX_CLK or posedge reset) begin
    if (reset) begin
      r_rx_cmd <= C_NONE;
      r_crs    <= 1'b0;
      r_rcv    <= 1'b0;
      r_bcnt   <= 8'd0;
    end else begin
      unique case (w_nstate)
        S_BEACON: begin
          r_rx_cmd <= C_BEACON;
          r_crs    <= 1'b1;
          r_rcv    <= 1'b0;
        end
        S_COMMIT: begin
          r_rx_cmd <= C_COMMIT;
          r_crs    <= 1'b1;
          r_rcv    <= 1'b0;
        end
        S_RECEIVE: begin
          r_rx_cmd <= C_NONE;
          r_crs    <= 1'b1;
          r_rcv    <= 1'b1;
        end
        default: begin
          r_rx_cmd <= C_NONE;
          r_crs    <= 1'b0;
          r_rcv    <= 1'b0;
        end
      endcase
      if ((w_nstate == S_BEACON) && (r_state != S_BEACON) &&
          (r_bcnt != 8'hFF)) begin
        r_bcnt <= r_bcnt + 8'd1;
      end
    end
  end

  assign rx_cmd     = r_rx_cmd;
  assign CRS        = r_crs;
  assign receiving  = r_rcv;
  assign beacon_cnt = r_bcnt;
  assign dec_state  = r_state;

endmodule
